gpio_h0_in_conditioner: RTL and testbench
=========================================

// Module: gpio_h0_in_conditioner
// PURPOSE
//  Conditions the raw asynchronous board pin that feeds the MCU hard-core's
//  gpio_h0_in. Stage sits directly upstream of the cortex_m3 wrapper in the ppm_clk domain.
//  - Synchronises the pin into ppm_clk, then debounces it by consecutive-sample qualification.
//  - Drives the clean level to gpio_h0_in and emits one-cycle rise/fall event pulses.
//  - Optionally keeps a saturating count of accepted edges.
// PARAMETERS
//  SYNC_STAGES      2   synchroniser flops, legal >= 2
//  DEBOUNCE_CYCLES  16  consecutive mismatching samples needed to accept a change, legal >= 1
//  CNT_W            16  width of edge_cnt, legal >= 1
//  INVERT           0   1 = gpio_h0_in, rise_pulse and fall_pulse refer to the inverted pin
// PORTS
//  ppm_clk       in   1      sole clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  pad_in        in   1      raw pin, asynchronous to ppm_clk
//  gpio_h0_in    out  1      debounced level, to MCU gpio_h0_in
//  rise_pulse    out  1      one-cycle pulse, gpio_h0_in went 0->1
//  fall_pulse    out  1      one-cycle pulse, gpio_h0_in went 1->0
//  stable        out  1      1 = no change being qualified (FSM in STABLE)
//  edge_cnt      out  CNT_W  accepted-edge count, saturating
//  edge_cnt_clr  in   1      synchronous clear of edge_cnt
// BEHAVIOUR
//  Reset (rst sampled high on a ppm_clk edge):
//   - sync chain=0, filt=0, deb_cnt=0, state=STABLE.
//   - Outputs: gpio_h0_in=INVERT, rise_pulse=0, fall_pulse=0, stable=1, edge_cnt=0.
//  Signal path:
//   - s = last sync flop. gpio_h0_in = filt ^ INVERT, driven from registered logic only.
//  FSM {STABLE, QUALIFY}, evaluated on every edge with rst=0:
//   - s==filt: deb_cnt<=0, state<=STABLE. A glitch is dropped with no output change.
//   - s!=filt, deb_cnt==DEBOUNCE_CYCLES-1: filt<=s, deb_cnt<=0, state<=STABLE,
//     and the matching pulse <=1.
//   - s!=filt otherwise: deb_cnt<=deb_cnt+1, state<=QUALIFY.
//  stable = (state==STABLE).
//  deb_cnt width = clog2(DEBOUNCE_CYCLES)+1; it never exceeds DEBOUNCE_CYCLES-1.
//  Latency:
//   - First flop samples the new pin level at edge E0.
//   - gpio_h0_in changes at edge E0+SYNC_STAGES-1+DEBOUNCE_CYCLES; defaults give 17 edges after E0.
//   - DEBOUNCE_CYCLES=1: filt follows s one cycle later and stable stays 1.
//  Pulses:
//   - Registered. High only in the cycle gpio_h0_in first shows its new level.
//   - Never both high. Cleared on the next edge.
//  Reset released while the pin is high: no pulse at reset exit. The high level is
//   qualified normally and then gives one rise_pulse (INVERT=0).
//  Reset mid-QUALIFY: partial count is discarded. The next change needs a full DEBOUNCE_CYCLES.
//  Pin toggling every cycle: filt never changes and no pulses are produced.
// CONFIGURATION
//  Macro GPIO_COND_EDGE_CNT_EN.
//  Defined:
//   - edge_cnt +1 on every cycle with rise_pulse|fall_pulse; saturates at 2^CNT_W-1.
//   - edge_cnt_clr=1 forces 0. If a pulse occurs in the same cycle, the result is 1 (edge counted after clear).
//  Undefined:
//   - No counter logic. edge_cnt is tied to 0 and edge_cnt_clr is ignored.
//   - Port list is unchanged.
// TESTING
//  1 rst=1 for 3 clks with pad_in=1 -> gpio_h0_in=0, stable=1, pulses=0, edge_cnt=0;
//    after release and qualification: exactly one rise_pulse.
//  2 Defaults, pad_in 0->1 held -> gpio_h0_in=1 exactly 17 edges after E0;
//    rise_pulse high 1 cycle in that same cycle; edge_cnt=1 (macro on).
//  3 s high for exactly 15 cycles then low -> gpio_h0_in stays 0, no pulse,
//    stable=0 during the high and 1 after.
//  4 s high exactly 16 cycles then low -> rise accepted;
//    fall_pulse 16 cycles after s falls; edge_cnt=2.
//  5 CNT_W=4, 20 accepted edges -> edge_cnt=15 (saturated);
//    clr coincident with an edge -> 1; clr alone -> 0.
//  6 rst pulsed while deb_cnt=8 -> all state cleared;
//    the held new level needs a full 16 further s-mismatch cycles to be accepted.

Source files
------------

// File: rtl/gpio_h0_in_conditioner_if.sv
// Pin-side signal bundle for gpio_h0_in_conditioner: raw pad in, conditioned level,
// edge event pulses, qualification status and the optional accepted-edge counter.
interface gpio_h0_in_conditioner_if #(
   parameter int CNT_W = 16
) ();
   logic             pad_in;
   logic             edge_cnt_clr;
   logic             gpio_h0_in;
   logic             rise_pulse;
   logic             fall_pulse;
   logic             stable;
   logic [CNT_W-1:0] edge_cnt;

   modport master (
      output pad_in,
      output edge_cnt_clr,
      input  gpio_h0_in,
      input  rise_pulse,
      input  fall_pulse,
      input  stable,
      input  edge_cnt
   );

   modport slave (
      input  pad_in,
      input  edge_cnt_clr,
      output gpio_h0_in,
      output rise_pulse,
      output fall_pulse,
      output stable,
      output edge_cnt
   );
endinterface

// File: rtl/gpio_h0_in_conditioner.sv
// Synchronises and debounces the raw gpio_h0_in pad into ppm_clk, with rise/fall pulses.
// Define GPIO_COND_EDGE_CNT_EN to build the saturating accepted-edge counter.
module gpio_h0_in_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16,
   parameter bit INVERT          = 1'b0
) (
   input logic                    ppm_clk,
   input logic                    rst,
   gpio_h0_in_conditioner_if.slave bus
);
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic                   filt_q, filt_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   always_ff @(posedge ppm_clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge ppm_clk) begin
      if (rst) begin
         state_q   <= STABLE;
         deb_cnt_q <= '0;
         filt_q    <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         filt_q    <= filt_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   // Any sample that agrees with the filtered level restarts qualification, so glitches vanish.
   always_comb begin
      state_d   = STABLE;
      deb_cnt_d = '0;
      filt_d    = filt_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      if (s != filt_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            filt_d = s;
            rise_d = s ^ INVERT;
            fall_d = ~(s ^ INVERT);
         end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
            state_d   = QUALIFY;
         end
      end
   end

   assign bus.gpio_h0_in = filt_q ^ INVERT;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.stable     = (state_q == STABLE);

`ifdef GPIO_COND_EDGE_CNT_EN
   logic             pulse;
   logic [CNT_W-1:0] edge_cnt_q;

   assign pulse = rise_q | fall_q;

   // A clear wins over the old value but still counts a pulse present in the same cycle.
   always_ff @(posedge ppm_clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
      end else if (bus.edge_cnt_clr) begin
         edge_cnt_q <= CNT_W'(pulse);
      end else if (pulse && (edge_cnt_q != '1)) begin
         edge_cnt_q <= edge_cnt_q + CNT_W'(1);
      end
   end

   assign bus.edge_cnt = edge_cnt_q;
`else
   logic unused_edge_cnt_clr;

   assign unused_edge_cnt_clr = bus.edge_cnt_clr;
   assign bus.edge_cnt        = '0;
`endif
endmodule

// File: tb/tb_gpio_h0_in_conditioner.sv
// Scoreboard bench for gpio_h0_in_conditioner: a default instance plus a DEBOUNCE_CYCLES=1,
// CNT_W=4 instance for counter saturation and clear behaviour.
module tb_gpio_h0_in_conditioner;
`ifdef GPIO_COND_EDGE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit rise;
      int cnt;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   ev_t  q0[$];
   ev_t  q4[$];
   int   model0 = 0;
   int   model4 = 0;
   bit   due0 = 1'b0;
   bit   due4 = 1'b0;
   int   due_cnt0 = 0;
   int   due_cnt4 = 0;

   gpio_h0_in_conditioner_if #(.CNT_W(16)) if0 ();
   gpio_h0_in_conditioner_if #(.CNT_W(4))  if4 ();

   gpio_h0_in_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .CNT_W(16), .INVERT(1'b0)
   ) dut0 (
      .ppm_clk(clk), .rst(rst), .bus(if0)
   );

   gpio_h0_in_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(4), .INVERT(1'b0)
   ) dut4 (
      .ppm_clk(clk), .rst(rst), .bus(if4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input int which, input logic val);
      if (which == 0) if0.pad_in = val;
      else            if4.pad_in = val;
   endtask

   // Expected edge for instance 0 or 4, with the counter model advanced in event order.
   task automatic expectEdge(input int which, input int at_cyc, input bit rise, input bit clr_same);
      ev_t e;
      int  cnt;
      int  cmax;
      cnt  = (which == 0) ? model0 : model4;
      cmax = (which == 0) ? 65535 : 15;
      if (clr_same) cnt = 1;
      else if (cnt < cmax) cnt = cnt + 1;
      if (which == 0) model0 = cnt;
      else            model4 = cnt;
      e.cyc  = at_cyc;
      e.rise = rise;
      e.cnt  = CNT_EN ? cnt : 0;
      if (which == 0) q0.push_back(e);
      else            q4.push_back(e);
   endtask

   task automatic monitorOne(input int which, input logic r, input logic f, input logic lvl,
                             input int cnt);
      ev_t   e;
      bit    have;
      string tag;
      tag  = (which == 0) ? "dut0" : "dut4";
      have = 1'b0;
      if (which == 0 && due0) begin
         checkOutput({tag, " edge_cnt"}, cnt, due_cnt0);
         due0 = 1'b0;
      end
      if (which == 1 && due4) begin
         checkOutput({tag, " edge_cnt"}, cnt, due_cnt4);
         due4 = 1'b0;
      end
      if (r || f) begin
         checkOutput({tag, " pulse exclusivity"}, int'(r && f), 0);
         if (which == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
         end else if (which == 1 && q4.size() > 0) begin
            e = q4.pop_front();
            have = 1'b1;
         end
         if (!have) begin
            checkOutput({tag, " unexpected pulse"}, 1, 0);
         end else begin
            checkOutput({tag, " pulse cycle"}, cyc, e.cyc);
            checkOutput({tag, " rise_pulse"}, int'(r), int'(e.rise));
            checkOutput({tag, " level at pulse"}, int'(lvl), int'(e.rise));
            if (which == 0) begin
               due0 = 1'b1;
               due_cnt0 = e.cnt;
            end else begin
               due4 = 1'b1;
               due_cnt4 = e.cnt;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         monitorOne(0, if0.rise_pulse, if0.fall_pulse, if0.gpio_h0_in, int'(if0.edge_cnt));
         monitorOne(1, if4.rise_pulse, if4.fall_pulse, if4.gpio_h0_in, int'(if4.edge_cnt));
      end
   end

   task automatic doReset(input logic pad0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, pad0);
      applyStimulus(1, 1'b0);
      waitCycles(3);
      checkOutput("reset gpio_h0_in", int'(if0.gpio_h0_in), 0);
      checkOutput("reset stable", int'(if0.stable), 1);
      checkOutput("reset pulses", int'(if0.rise_pulse | if0.fall_pulse), 0);
      checkOutput("reset edge_cnt", int'(if0.edge_cnt), 0);
      checkOutput("reset dut4 gpio_h0_in", int'(if4.gpio_h0_in), 0);
      checkOutput("reset dut4 stable", int'(if4.stable), 1);
      model0 = 0;
      model4 = 0;
      rst = 1'b0;
   endtask

   initial begin
      int c;
      if0.pad_in = 1'b0;
      if0.edge_cnt_clr = 1'b0;
      if4.pad_in = 1'b0;
      if4.edge_cnt_clr = 1'b0;

      // Reset held with the pad high: one rise once the level qualifies after release.
      doReset(1'b1);
      c = cyc;
      expectEdge(0, c + 18, 1'b1, 1'b0);
      waitCycles(25);
      checkOutput("post-reset high level", int'(if0.gpio_h0_in), 1);

      // Single rise with default latency.
      doReset(1'b0);
      c = cyc;
      applyStimulus(0, 1'b1);
      expectEdge(0, c + 18, 1'b1, 1'b0);
      waitCycles(17);
      checkOutput("rise not early", int'(if0.gpio_h0_in), 0);
      waitCycles(3);
      checkOutput("stable after rise", int'(if0.stable), 1);

      // Fifteen samples high is one short of acceptance.
      doReset(1'b0);
      c = cyc;
      applyStimulus(0, 1'b1);
      waitCycles(8);
      checkOutput("stable during short high", int'(if0.stable), 0);
      waitCycles(7);
      applyStimulus(0, 1'b0);
      waitCycles(6);
      checkOutput("stable after short high", int'(if0.stable), 1);
      checkOutput("short high rejected", int'(if0.gpio_h0_in), 0);

      // Sixteen samples high is accepted, then the fall qualifies.
      doReset(1'b0);
      c = cyc;
      applyStimulus(0, 1'b1);
      expectEdge(0, c + 18, 1'b1, 1'b0);
      waitCycles(16);
      applyStimulus(0, 1'b0);
      expectEdge(0, c + 34, 1'b0, 1'b0);
      waitCycles(24);
      checkOutput("level after fall", int'(if0.gpio_h0_in), 0);

      // Reset in the middle of qualification discards the partial count.
      doReset(1'b0);
      c = cyc;
      applyStimulus(0, 1'b1);
      waitCycles(10);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("mid-qualify reset stable", int'(if0.stable), 1);
      checkOutput("mid-qualify reset level", int'(if0.gpio_h0_in), 0);
      rst = 1'b0;
      c = cyc;
      expectEdge(0, c + 18, 1'b1, 1'b0);
      waitCycles(17);
      checkOutput("full requalify needed", int'(if0.gpio_h0_in), 0);
      waitCycles(5);

      // Pad toggling every cycle never qualifies.
      doReset(1'b0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, ~if0.pad_in);
         waitCycles(1);
      end
      applyStimulus(0, 1'b0);
      waitCycles(20);
      checkOutput("toggle level", int'(if0.gpio_h0_in), 0);
      checkOutput("toggle stable", int'(if0.stable), 1);

      // Counter saturation, clear with a coincident pulse, then a plain clear.
      doReset(1'b0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, ~if4.pad_in);
         expectEdge(1, cyc + 3, if4.pad_in, 1'b0);
         waitCycles(2);
      end
      waitCycles(4);
      c = cyc;
      applyStimulus(1, 1'b1);
      expectEdge(1, c + 3, 1'b1, 1'b1);
      waitCycles(3);
      if4.edge_cnt_clr = 1'b1;
      waitCycles(1);
      if4.edge_cnt_clr = 1'b0;
      waitCycles(3);
      if4.edge_cnt_clr = 1'b1;
      waitCycles(1);
      if4.edge_cnt_clr = 1'b0;
      checkOutput("clear alone", int'(if4.edge_cnt), 0);
      waitCycles(3);

      checkOutput("dut0 missing events", q0.size(), 0);
      checkOutput("dut4 missing events", q4.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
